// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digit_scan_ctrl: 4-digit multiplexed display scanner, double-buffered    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module digit_scan_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int DEAD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_digit_mask,
  input  logic        i_lz_blank,
  output logic [1:0]  o_sel,
  output logic        o_sel_en,
  output logic [3:0]  o_nibble,
  output logic        o_pending,
  output logic        o_frame_done
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic [15:0]   r_active, w_active_nxt;
  logic [15:0]   r_shadow, w_shadow_nxt;
  logic          r_pending, w_pending_nxt;

  logic          w_scan;
  logic          w_last;
  logic          w_wrap;
  logic          w_past_dead;
  logic [3:0]    w_vis;
  logic [3:0]    w_nib;

  assign w_scan = (r_state == ST_SCAN);
  assign w_last = (r_cnt == C_LAST);
  assign w_wrap = w_scan && w_last && (r_sel == 2'd3);

  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_past_dead = 1'b1;
    end else begin : g_dead
      assign w_past_dead = (r_cnt >= CW'(DEAD));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_sel     <= 2'd0;
      r_active  <= 16'd0;
      r_shadow  <= 16'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sel_nxt     = r_sel;
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    case (r_state)
      ST_BLANK: begin
        w_cnt_nxt = '0;
        w_sel_nxt = 2'd0;
        if (i_load) begin
          w_state_nxt   = ST_SCAN;
          w_active_nxt  = i_value;
          w_pending_nxt = 1'b0;
        end
      end
      ST_SCAN: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          w_sel_nxt = r_sel + 2'd1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        // A load coinciding with the wrap bypasses the shadow entirely.
        if (i_load && w_wrap) begin
          w_active_nxt  = i_value;
          w_pending_nxt = 1'b0;
        end else if (i_load) begin
          w_shadow_nxt  = i_value;
          w_pending_nxt = 1'b1;
        end else if (w_wrap && r_pending) begin
          w_active_nxt  = r_shadow;
          w_pending_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
      end
    endcase
  end

  // Digit k is dark under zero-suppression when it and every higher nibble are 0.
  assign w_vis[0] = i_digit_mask[0];
  assign w_vis[1] = i_digit_mask[1] && !(i_lz_blank && (r_active[15:4]  == 12'd0));
  assign w_vis[2] = i_digit_mask[2] && !(i_lz_blank && (r_active[15:8]  == 8'd0));
  assign w_vis[3] = i_digit_mask[3] && !(i_lz_blank && (r_active[15:12] == 4'd0));

  assign w_nib        = r_active[{r_sel, 2'b00} +: 4];
  assign o_sel        = r_sel;
  assign o_sel_en     = w_scan && w_past_dead && w_vis[r_sel];
  assign o_nibble     = o_sel_en ? w_nib : 4'd0;
  assign o_pending    = r_pending;
  assign o_frame_done = w_wrap;

endmodule
`default_nettype wire
